// File: rtl/sa_tile_sequencer_pkg.sv
// Shared command encoding for the systolic array control interface.
package sa_tile_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_NONE          = 3'd0,
    CMD_WRITE_WEIGHTS = 3'd1,
    CMD_QUEUE_INPUT   = 3'd2,
    CMD_STEP          = 3'd3,
    CMD_READ_OUTPUT   = 3'd4
  } command_t;

endpackage

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer: loads one weight tile, streams activation rows through the
// systolic array, flushes the pipeline and returns each result row in order.
module sa_tile_sequencer
  import sa_tile_sequencer_pkg::*;
#(
  parameter int unsigned SA_SIZE      = 4,
  parameter int unsigned WEIGHT_WORDS = SA_SIZE * SA_SIZE / 4,
  parameter int unsigned OUT_LATENCY  = 2 * SA_SIZE - 1,
  parameter int unsigned ROW_W        = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [ROW_W-1:0]           num_rows,
  output logic                       busy,
  output logic                       done,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                sa_in_val,
  output logic [$clog2(SA_SIZE)-1:0] sa_in_idx,
  output command_t                   sa_cmd,
  input  logic [31:0]                sa_out
);

  localparam int unsigned IDX_W  = $clog2(SA_SIZE);
  localparam int unsigned CNT_W  = ROW_W + 1;
  localparam int unsigned WCNT_W = (WEIGHT_WORDS > 1) ? $clog2(WEIGHT_WORDS) : 1;

  localparam logic [CNT_W-1:0]  LAT       = CNT_W'(OUT_LATENCY);
  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(SA_SIZE - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WEIGHT_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    STEP   = 3'd3,
    READ   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  s, s_d;        // compute step index within the job
  logic [CNT_W-1:0]  m, m_d;        // latched row count
  logic [IDX_W-1:0]  col, col_d;    // next column to queue / read
  logic [IDX_W-1:0]  rcol, rcol_d;  // next column to capture from the array
  logic [WCNT_W-1:0] wcnt, wcnt_d;  // weight words accepted so far
  logic              rd_issued, rd_issued_d;  // read command on the wire
  logic              rd_land, rd_land_d;      // array output valid this cycle

  logic              busy_d, done_d, in_ready_d, out_valid_d;
  logic [31:0]       out_data_d, sa_in_val_d;
  logic [IDX_W-1:0]  sa_in_idx_d;
  command_t          sa_cmd_d;

  logic              accept;
  logic              feed_go;
  logic [CNT_W-1:0]  s_next;
  logic              job_end;

  assign accept  = in_valid && in_ready;
  assign s_next  = s + CNT_W'(1);
  assign job_end = (s_next == (m + LAT));

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      s         <= '0;
      m         <= '0;
      col       <= '0;
      rcol      <= '0;
      wcnt      <= '0;
      rd_issued <= 1'b0;
      rd_land   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sa_in_val <= '0;
      sa_in_idx <= '0;
      sa_cmd    <= CMD_NONE;
    end else begin
      state     <= state_d;
      s         <= s_d;
      m         <= m_d;
      col       <= col_d;
      rcol      <= rcol_d;
      wcnt      <= wcnt_d;
      rd_issued <= rd_issued_d;
      rd_land   <= rd_land_d;
      busy      <= busy_d;
      done      <= done_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      sa_in_val <= sa_in_val_d;
      sa_in_idx <= sa_in_idx_d;
      sa_cmd    <= sa_cmd_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state;
    s_d         = s;
    m_d         = m;
    col_d       = col;
    rcol_d      = rcol;
    wcnt_d      = wcnt;
    rd_issued_d = 1'b0;
    rd_land_d   = rd_issued;
    busy_d      = busy;
    done_d      = 1'b0;
    out_valid_d = out_valid && !out_ready;
    out_data_d  = out_data;
    sa_in_val_d = '0;
    sa_in_idx_d = '0;
    sa_cmd_d    = CMD_NONE;
    feed_go     = 1'b0;

    // Array result lands one cycle after the read command; reads are
    // serialised so the output register is always free here.
    if (rd_land) begin
      out_data_d  = sa_out;
      out_valid_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          m_d     = CNT_W'(num_rows);
          s_d     = '0;
          col_d   = '0;
          rcol_d  = '0;
          wcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = LOAD_W;
        end
      end

      LOAD_W: begin
        if (accept) begin
          sa_cmd_d    = CMD_WRITE_WEIGHTS;
          sa_in_val_d = in_data;
          if (wcnt == LAST_WORD) begin
            wcnt_d  = '0;
            s_d     = '0;
            col_d   = '0;
            state_d = FEED;
          end else begin
            wcnt_d = wcnt + WCNT_W'(1);
          end
        end
      end

      FEED: begin
        if (s < m) begin
          if (accept) begin
            sa_cmd_d    = CMD_QUEUE_INPUT;
            sa_in_val_d = in_data;
            sa_in_idx_d = col;
            feed_go     = 1'b1;
          end
        end else begin
          // Flush step: zeros push earlier rows through the pipeline.
          sa_cmd_d    = CMD_QUEUE_INPUT;
          sa_in_val_d = '0;
          sa_in_idx_d = col;
          feed_go     = 1'b1;
        end
        if (feed_go) begin
          if (col == LAST_COL) begin
            col_d   = '0;
            state_d = STEP;
          end else begin
            col_d = col + IDX_W'(1);
          end
        end
      end

      STEP: begin
        sa_cmd_d = CMD_STEP;
        if ((s >= LAT) && (s < (m + LAT))) begin
          col_d   = '0;
          rcol_d  = '0;
          state_d = READ;
        end else begin
          s_d     = s_next;
          state_d = job_end ? DONE : FEED;
        end
      end

      READ: begin
        if (!rd_issued && !rd_land && (!out_valid || out_ready)) begin
          sa_cmd_d    = CMD_READ_OUTPUT;
          sa_in_idx_d = col;
          rd_issued_d = 1'b1;
          col_d       = col + IDX_W'(1);
        end
        if (rd_land) begin
          if (rcol == LAST_COL) begin
            rcol_d  = '0;
            col_d   = '0;
            s_d     = s_next;
            state_d = job_end ? DONE : FEED;
          end else begin
            rcol_d = rcol + IDX_W'(1);
          end
        end
      end

      DONE: begin
        if (!out_valid) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD_W) || ((state_d == FEED) && (s_d < m_d));
  end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Randomised bench: drives jobs through the sequencer against a behavioural
// array stub and checks data order, word counts, command counts and handshakes.
module tb_sa_tile_sequencer;
  import sa_tile_sequencer_pkg::*;

  localparam int unsigned SA = 4;
  localparam int unsigned WW = SA * SA / 4;
  localparam int unsigned OL = 2 * SA - 1;
  localparam int unsigned IW = $clog2(SA);

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [15:0]   num_rows;
  logic          busy, done;
  logic [31:0]   in_data;
  logic          in_valid, in_ready;
  logic [31:0]   out_data;
  logic          out_valid, out_ready;
  logic [31:0]   sa_in_val;
  logic [IW-1:0] sa_in_idx;
  command_t      sa_cmd;
  logic [31:0]   sa_out;

  sa_tile_sequencer #(.SA_SIZE(SA), .ROW_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sa_in_val(sa_in_val), .sa_in_idx(sa_in_idx),
    .sa_cmd(sa_cmd), .sa_out(sa_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] in_q[$];
  logic [31:0] got_q[$];
  int consumed, steps, qnz, qz, rcnt, done_cnt, stall_cnt;
  int vmode, rmode;
  logic prev_stall, prev_busy, prev_done;
  logic [31:0] prev_od;

  // Array stub state
  logic [31:0] stub_w[WW];
  int          stub_wn;
  logic [31:0] stub_a[SA];
  logic [31:0] stub_rows[$];
  command_t    stub_last;
  logic        rd_pend;
  logic [31:0] rd_val;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Array result: weights are a 0/1 permutation, so each output column picks one input.
  function automatic logic [31:0] stub_result(input int row, input int c);
    logic [31:0] r;
    int k;
    if (row < 0 || (row + 1) * SA > stub_rows.size()) return 32'hDEAD_BEEF;
    r = 32'h0;
    for (int i = 0; i < SA; i++) begin
      k = i * SA + c;
      if (stub_w[k / 4][8 * (k % 4) +: 8] != 8'h00) r = stub_rows[row * SA + i];
    end
    return r;
  endfunction

  // Input/output handshake drivers and array output, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (in_q.size() > 0 && (vmode == 0 || $urandom_range(1, 0) == 1)) begin
      in_valid = 1'b1;
      in_data  = in_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(1, 0) == 1);
      default: begin
        if (out_valid && stall_cnt < 20) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
    if (rd_pend) begin
      sa_out  = rd_val;
      rd_pend = 1'b0;
    end
  end

  // Monitor and array stub, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] dummy;
    if (!resetn) begin
      stub_rows.delete();
      stub_wn    = 0;
      stub_last  = CMD_NONE;
      rd_pend    = 1'b0;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (in_q.size() > 0) dummy = in_q.pop_front();
        consumed++;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(prev_od));
      end
      if (sa_cmd == CMD_READ_OUTPUT) chk("read_while_full", 64'(prev_stall), 64'(0));
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", 64'(busy), 64'(0));
        chk("busy_before_done", 64'(prev_busy), 64'(1));
        chk("done_one_cycle", 64'(prev_done), 64'(0));
      end
      prev_stall = out_valid && !out_ready;
      prev_od    = out_data;
      prev_busy  = busy;
      prev_done  = done;

      case (sa_cmd)
        CMD_WRITE_WEIGHTS: begin
          if (stub_last != CMD_WRITE_WEIGHTS) begin
            stub_wn = 0;
            stub_rows.delete();
          end
          if (stub_wn < WW) stub_w[stub_wn] = sa_in_val;
          stub_wn++;
        end
        CMD_QUEUE_INPUT: begin
          stub_a[sa_in_idx] = sa_in_val;
          if (sa_in_val == 32'h0) qz++;
          else qnz++;
        end
        CMD_STEP: begin
          for (int i = 0; i < SA; i++) stub_rows.push_back(stub_a[i]);
          steps++;
        end
        CMD_READ_OUTPUT: begin
          rcnt++;
          rd_val  = stub_result(stub_rows.size() / SA - 1 - OL, int'(sa_in_idx));
          rd_pend = 1'b1;
        end
        default: ;
      endcase
      if (sa_cmd != CMD_NONE) stub_last = sa_cmd;
    end
  end

  task automatic pulse_start(input int m);
    @(posedge clk);
    #1;
    start    = 1'b1;
    num_rows = 16'(m);
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_rows = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
    chk({tag, "_sa_in_val"}, 64'(sa_in_val), 64'(0));
    chk({tag, "_sa_in_idx"}, 64'(sa_in_idx), 64'(0));
    chk({tag, "_sa_cmd"},    64'(sa_cmd),    64'(CMD_NONE));
  endtask

  // Build a job (weights, activations, trailing spare words), run it, check totals.
  task automatic run_job(input int m, input int vm, input int rm, input bit use_perm, input bit spur);
    logic [31:0] wts[$];
    logic [31:0] exp_q[$];
    logic [31:0] act[SA];
    logic [31:0] erow[SA];
    logic [31:0] wd;
    int p[SA];
    int e, j, t, cyc;

    for (int i = 0; i < SA; i++) p[i] = i;
    if (use_perm) begin
      for (int i = SA - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = p[i]; p[i] = p[j]; p[j] = t;
      end
    end
    for (int k = 0; k < WW; k++) begin
      wd = 32'h0;
      for (int b = 0; b < 4; b++) begin
        e = k * 4 + b;
        if (p[e / SA] == e % SA) wd[8 * b +: 8] = 8'h01;
      end
      wts.push_back(wd);
    end

    consumed = 0; steps = 0; qnz = 0; qz = 0; rcnt = 0; done_cnt = 0; stall_cnt = 0;
    got_q.delete();
    in_q.delete();
    vmode = vm;
    rmode = rm;
    foreach (wts[k]) in_q.push_back(wts[k]);
    for (int r = 0; r < m; r++) begin
      for (int i = 0; i < SA; i++) begin
        act[i] = $urandom | 32'h1;
        in_q.push_back(act[i]);
        erow[p[i]] = act[i];
      end
      for (int c = 0; c < SA; c++) exp_q.push_back(erow[c]);
    end
    for (int i = 0; i < SA; i++) in_q.push_back($urandom | 32'h1);

    pulse_start(m);
    cyc = 0;
    if (spur) begin
      repeat (30) @(posedge clk);
      pulse_start(7);
    end
    while (done_cnt == 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    chk("job_timeout", 64'(done_cnt != 0), 64'(1));
    repeat (10) @(posedge clk);

    chk("in_words", 64'(consumed), 64'(WW + SA * m));
    chk("out_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) chk($sformatf("out_word%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
    chk("step_cmds", 64'(steps), 64'(m + OL));
    chk("queue_data_cmds", 64'(qnz), 64'(SA * m));
    chk("queue_flush_cmds", 64'(qz), 64'(SA * OL));
    chk("read_cmds", 64'(rcnt), 64'(SA * m));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("weight_writes", 64'(stub_wn), 64'(WW));
    for (int k = 0; k < WW; k++) chk($sformatf("weight%0d", k), 64'(stub_w[k]), 64'(wts[k]));
    chk("busy_idle", 64'(busy), 64'(0));
    if (rm == 2) chk("stall_cycles", 64'(stall_cnt), 64'(20));
    in_q.delete();
  endtask

  // Abort a running job with reset mid-way through the second row.
  task automatic run_abort();
    int cyc;
    logic [31:0] q;
    consumed = 0; done_cnt = 0; stall_cnt = 0;
    vmode = 0;
    rmode = 0;
    in_q.delete();
    for (int i = 0; i < WW + 3 * SA; i++) begin
      q = $urandom | 32'h1;
      in_q.push_back(q);
    end
    pulse_start(3);
    cyc = 0;
    while (consumed < WW + SA + 2 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk("abort_reach_feed", 64'(consumed >= WW + SA + 2), 64'(1));
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    in_q.delete();
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; num_rows = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sa_out = '0;
    vmode = 0; rmode = 0; rd_pend = 1'b0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    run_job(3, 0, 0, 1'b0, 1'b0);
    run_job(3, 1, 0, 1'b0, 1'b0);
    run_job(3, 0, 2, 1'b0, 1'b0);
    run_job(0, 0, 0, 1'b0, 1'b0);
    run_abort();
    run_job(1, 0, 0, 1'b0, 1'b0);
    run_job(2, 1, 1, 1'b1, 1'b1);
    run_job(5, 1, 1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
